viterbi_burst_channel: RTL and testbench

Parametrised, synthesisable channel model placed between the convolutional encoder and the Viterbi decoder. It replaces ad-hoc `$random` error injection with a seeded LFSR and injects configurable error bursts with selectable corruption modes. Every output symbol is registered, together with a per-symbol error mask. Optional statistics counters let the bench compare decoder output against the true channel error count.

---
 rtl/viterbi_burst_channel_pkg.sv | 18 +
 rtl/viterbi_burst_channel_lfsr.sv | 22 ++
 rtl/viterbi_burst_channel.sv | 172 +++++++++++++++++
 tb/tb_viterbi_burst_channel.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_burst_channel_pkg.sv
// Shared types and constants for the Viterbi channel model and its noise sources.
package viterbi_pkg;

  typedef enum logic [1:0] {
    CH_PASS   = 2'd0,
    CH_INVERT = 2'd1,
    CH_FLIP1  = 2'd2,
    CH_STUCK0 = 2'd3
  } ch_mode_t;

  typedef enum logic {
    CH_IDLE  = 1'b0,
    CH_BURST = 1'b1
  } ch_state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/viterbi_burst_channel_lfsr.sv
// 32-bit right-shifting Galois LFSR with seedable reset and advance enable.
module channel_lfsr
  import viterbi_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_1234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_adv,
  output logic [31:0] o_lfsr
);

  logic [31:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_lfsr <= SEED;
    else if (i_adv) r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/viterbi_burst_channel.sv
// Seeded burst-error channel between convolutional encoder and Viterbi decoder.
// Statistics counters are built only when VITERBI_CHANNEL_STATS_EN is defined.
//
//   state    | meaning
//   CH_IDLE  | passing symbols clean, watching for a trigger
//   CH_BURST | corrupting symbols until rem runs out or injection drops
module viterbi_burst_channel
  import viterbi_pkg::*;
#(
  parameter int          SYM_W     = 2,
  parameter int          RATE_N    = 5,
  parameter int          MAX_BURST = 4,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_1234,
  parameter int          BL_W      = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [SYM_W-1:0] sym_i,
  input  logic             inject_en_i,
  input  logic             force_i,
  input  logic [1:0]       mode_i,
  input  logic [BL_W-1:0]  burst_len_i,
  input  logic             clear_stats_i,
  output logic             valid_o,
  output logic [SYM_W-1:0] sym_o,
  output logic [SYM_W-1:0] err_o,
  output logic             busy_o,
  output logic [31:0]      sym_count_o,
  output logic [31:0]      bit_err_count_o,
  output logic [15:0]      burst_count_o
);

  localparam int KW = (SYM_W > 1) ? $clog2(SYM_W) : 1;
  localparam int PW = $clog2(SYM_W + 1);
  localparam logic [BL_W-1:0] MAXB = BL_W'(MAX_BURST);

  ch_state_t        r_state, w_state_nxt;
  logic [BL_W-1:0]  r_rem, w_rem_nxt;
  ch_mode_t         r_mode, w_mode_eff;
  logic [KW-1:0]    r_k, w_k_eff, w_k_new;
  logic [31:0]      w_lfsr;
  logic [BL_W-1:0]  w_len;
  logic [4:0]       w_k_raw, w_k_mod;
  logic             w_trig, w_corrupt;
  logic [SYM_W-1:0] w_mask;
  logic [PW-1:0]    w_pop;

  channel_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_adv  (valid_i),
    .o_lfsr (w_lfsr)
  );

  assign w_len   = (burst_len_i > MAXB) ? MAXB : burst_len_i;
  assign w_k_raw = w_lfsr[RATE_N+4:RATE_N];
  assign w_k_mod = w_k_raw % 5'(SYM_W);
  assign w_k_new = w_k_mod[KW-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_trig      = 1'b0;
    w_corrupt   = 1'b0;
    w_mode_eff  = r_mode;
    w_k_eff     = r_k;
    case (r_state)
      CH_IDLE: begin
        if (valid_i && inject_en_i && (ch_mode_t'(mode_i) != CH_PASS) && (w_len != '0) &&
            ((&w_lfsr[RATE_N-1:0]) || force_i)) begin
          w_trig      = 1'b1;
          w_corrupt   = 1'b1;
          w_mode_eff  = ch_mode_t'(mode_i);
          w_k_eff     = w_k_new;
          w_rem_nxt   = w_len - BL_W'(1);
          w_state_nxt = (w_len > BL_W'(1)) ? CH_BURST : CH_IDLE;
        end
      end
      CH_BURST: begin
        if (valid_i) begin
          if (!inject_en_i) begin
            w_rem_nxt   = '0;
            w_state_nxt = CH_IDLE;
          end else begin
            w_corrupt = 1'b1;
            w_rem_nxt = r_rem - BL_W'(1);
            if (r_rem == BL_W'(1)) w_state_nxt = CH_IDLE;
          end
        end
      end
      default: w_state_nxt = CH_IDLE;
    endcase
  end

  always_comb begin
    w_mask = '0;
    if (w_corrupt) begin
      case (w_mode_eff)
        CH_INVERT: w_mask = '1;
        CH_FLIP1:  w_mask = SYM_W'(1) << w_k_eff;
        CH_STUCK0: w_mask = sym_i;
        default:   w_mask = '0;
      endcase
    end
    w_pop = '0;
    for (int i = 0; i < SYM_W; i++) w_pop = w_pop + PW'(w_mask[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CH_IDLE;
      r_rem   <= '0;
      r_mode  <= CH_PASS;
      r_k     <= '0;
      valid_o <= 1'b0;
      sym_o   <= '0;
      err_o   <= '0;
      busy_o  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      if (w_trig) begin
        r_mode <= w_mode_eff;
        r_k    <= w_k_eff;
      end
      valid_o <= valid_i;
      if (valid_i) sym_o <= sym_i ^ w_mask;
      err_o   <= valid_i ? w_mask : '0;
      busy_o  <= (w_state_nxt == CH_BURST);
    end
  end

  logic w_unused_lfsr;
  assign w_unused_lfsr = ^w_lfsr[31:RATE_N+5];

`ifdef VITERBI_CHANNEL_STATS_EN
  logic [31:0] r_sym_cnt, r_bit_cnt;
  logic [15:0] r_burst_cnt;
  logic [32:0] w_bit_sum;

  // Sum one bit wider so saturation can be detected from the carry.
  assign w_bit_sum = {1'b0, r_bit_cnt} + 33'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sym_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_burst_cnt <= '0;
    end else if (clear_stats_i) begin
      r_sym_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_burst_cnt <= '0;
    end else begin
      if (valid_i && (r_sym_cnt != '1)) r_sym_cnt <= r_sym_cnt + 32'd1;
      if (w_trig && (r_burst_cnt != '1)) r_burst_cnt <= r_burst_cnt + 16'd1;
      r_bit_cnt <= w_bit_sum[32] ? '1 : w_bit_sum[31:0];
    end
  end

  assign sym_count_o     = r_sym_cnt;
  assign bit_err_count_o = r_bit_cnt;
  assign burst_count_o   = r_burst_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats  = ^{clear_stats_i, w_pop};
  assign sym_count_o     = '0;
  assign bit_err_count_o = '0;
  assign burst_count_o   = '0;
`endif

endmodule

// File: tb/tb_viterbi_burst_channel.sv
// Directed self-checking bench for viterbi_burst_channel (default parameters).
module tb_viterbi_burst_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [1:0]  sym_i;
  logic        inject_en_i;
  logic        force_i;
  logic [1:0]  mode_i;
  logic [2:0]  burst_len_i;
  logic        clear_stats_i;
  logic        valid_o;
  logic [1:0]  sym_o;
  logic [1:0]  err_o;
  logic        busy_o;
  logic [31:0] sym_count_o;
  logic [31:0] bit_err_count_o;
  logic [15:0] burst_count_o;

`ifdef VITERBI_CHANNEL_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] ref_err [4096];

  viterbi_burst_channel dut (
    .clk             (clk),
    .rst             (rst),
    .valid_i         (valid_i),
    .sym_i           (sym_i),
    .inject_en_i     (inject_en_i),
    .force_i         (force_i),
    .mode_i          (mode_i),
    .burst_len_i     (burst_len_i),
    .clear_stats_i   (clear_stats_i),
    .valid_o         (valid_o),
    .sym_o           (sym_o),
    .err_o           (err_o),
    .busy_o          (busy_o),
    .sym_count_o     (sym_count_o),
    .bit_err_count_o (bit_err_count_o),
    .burst_count_o   (burst_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] s);
    valid_i = v;
    sym_i   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_i = 1'b0; sym_i = 2'b00; inject_en_i = 1'b0; force_i = 1'b0;
    mode_i = 2'd0; burst_len_i = 3'd0; clear_stats_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int bad, nz, mism, idx, cyc;
    logic [1:0] s, last;
    logic v;
    logic [1:0] e2_sym [5];
    logic       e2_busy [5];
    logic [1:0] e3_in [5];
    logic       e3_busy [5];
    logic [1:0] e4_in [3];
    logic [1:0] e4_sym [3];
    logic [1:0] e4_err [3];
    logic       t5_inj [5], t5_frc [5];
    logic [1:0] t5_mode [5], t5_err [5];
    logic [2:0] t5_len [5];

    e2_sym  = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    e2_busy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    e3_in   = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    e3_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    e4_in   = '{2'b11, 2'b10, 2'b01};
    e4_sym  = '{2'b00, 2'b00, 2'b01};
    e4_err  = '{2'b11, 2'b10, 2'b00};
    t5_inj  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    t5_frc  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    t5_mode = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd0};
    t5_len  = '{3'd4, 3'd4, 3'd4, 3'd1, 3'd1};
    t5_err  = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b00};

    // Reset values
    do_reset();
    chk("rst_valid", valid_o, 0);
    chk("rst_sym", sym_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_symcnt", sym_count_o, 0);
    chk("rst_bitcnt", bit_err_count_o, 0);
    chk("rst_burstcnt", burst_count_o, 0);

    // Clean pass-through with injection disabled
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      s = 2'($urandom_range(0, 3));
      step(1'b1, s);
      if (sym_o !== s || err_o !== 2'b00 || valid_o !== 1'b1) bad++;
    end
    chk("pass_through", bad, 0);
    chk("pass_symcnt", sym_count_o, STATS * 100);
    chk("pass_bitcnt", bit_err_count_o, 0);

    last = sym_o;
    step(1'b0, ~last);
    chk("gap_valid", valid_o, 0);
    chk("gap_hold", sym_o, last);
    chk("gap_err", err_o, 0);
    chk("gap_symcnt", sym_count_o, STATS * 100);

    clear_stats_i = 1'b1;
    step(1'b1, 2'b00);
    clear_stats_i = 1'b0;
    chk("clear_symcnt", sym_count_o, 0);

    // Forced invert burst of 3; mode dropped to 0 after trigger is ignored mid-burst
    do_reset();
    inject_en_i = 1'b1; mode_i = 2'd1; burst_len_i = 3'd3; force_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'b01);
      force_i = 1'b0; mode_i = 2'd0;
      chk($sformatf("inv_sym%0d", i), sym_o, e2_sym[i]);
      chk($sformatf("inv_busy%0d", i), busy_o, e2_busy[i]);
    end
    chk("inv_burstcnt", burst_count_o, STATS * 1);
    chk("inv_bitcnt", bit_err_count_o, STATS * 6);

    // Flip-one burst, length clamped 7 -> 4; seed gives k = 1
    do_reset();
    inject_en_i = 1'b1; mode_i = 2'd2; burst_len_i = 3'd7; force_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, e3_in[i]);
      force_i = 1'b0; mode_i = 2'd0;
      chk($sformatf("flip_err%0d", i), err_o, (i < 4) ? 2'b10 : 2'b00);
      chk($sformatf("flip_sym%0d", i), sym_o, e3_in[i] ^ ((i < 4) ? 2'b10 : 2'b00));
      chk($sformatf("flip_busy%0d", i), busy_o, e3_busy[i]);
    end
    chk("flip_bitcnt", bit_err_count_o, STATS * 4);

    // Stuck-at-zero burst of 2
    do_reset();
    inject_en_i = 1'b1; mode_i = 2'd3; burst_len_i = 3'd2; force_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, e4_in[i]);
      force_i = 1'b0; mode_i = 2'd0;
      chk($sformatf("stk_sym%0d", i), sym_o, e4_sym[i]);
      chk($sformatf("stk_err%0d", i), err_o, e4_err[i]);
    end
    chk("stk_bitcnt", bit_err_count_o, STATS * 3);

    // Abort on inject_en drop, then a fresh forced burst
    do_reset();
    for (int i = 0; i < 5; i++) begin
      inject_en_i = t5_inj[i]; force_i = t5_frc[i]; mode_i = t5_mode[i]; burst_len_i = t5_len[i];
      step(1'b1, 2'b00);
      chk($sformatf("abort_err%0d", i), err_o, t5_err[i]);
      chk($sformatf("abort_busy%0d", i), busy_o, (i == 0) ? 1'b1 : 1'b0);
    end
    chk("abort_burstcnt", burst_count_o, STATS * 2);

    // Reset in the middle of a burst
    do_reset();
    inject_en_i = 1'b1; mode_i = 2'd1; burst_len_i = 3'd4; force_i = 1'b1;
    step(1'b1, 2'b00);
    chk("mid_busy_pre", busy_o, 1);
    rst = 1'b1;
    #2;
    chk("mid_busy_rst", busy_o, 0);
    chk("mid_err_rst", err_o, 0);
    @(posedge clk); #1;
    rst = 1'b0; force_i = 1'b0; mode_i = 2'd0;
    step(1'b1, 2'b01);
    chk("mid_post_sym", sym_o, 2'b01);
    chk("mid_post_busy", busy_o, 0);

    // Free-running injection at 2^-5 with single-symbol bursts
    do_reset();
    inject_en_i = 1'b1; mode_i = 2'd1; burst_len_i = 3'd1; force_i = 1'b0;
    nz = 0;
    for (int i = 0; i < 65536; i++) begin
      step(1'b1, 2'b00);
      if (err_o != 2'b00) nz++;
      if (i < 4096) ref_err[i] = err_o;
    end
    chk("rate_window", (nz >= 1843 && nz <= 2253) ? 32'd1 : 32'd0, 1);
    chk("rate_burstcnt", burst_count_o, STATS * nz);
    chk("rate_bitcnt", bit_err_count_o, STATS * 2 * nz);

    // Same seed with valid gaps must reproduce the error sequence
    do_reset();
    inject_en_i = 1'b1; mode_i = 2'd1; burst_len_i = 3'd1; force_i = 1'b0;
    mism = 0; idx = 0; cyc = 0;
    while (idx < 4096 && cyc < 16000) begin
      v = ($urandom_range(0, 2) != 0);
      step(v, 2'b00);
      if (v) begin
        if (err_o !== ref_err[idx]) mism++;
        idx++;
      end else if (err_o !== 2'b00 || valid_o !== 1'b0) begin
        mism++;
      end
      cyc++;
    end
    chk("gap_seq", mism, 0);
    chk("gap_done", idx, 4096);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
